// File: rtl/act_buf_stream_reader_pkg.sv
// act_buf_stream_reader_pkg: shared state encoding, width defaults and token constants
package act_buf_stream_reader_pkg;
  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 14;
  localparam logic TOKEN_FULL = 1'b1;
  localparam logic TOKEN_FREE = 1'b1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;
endpackage

// File: rtl/act_skid_fifo.sv
// act_skid_fifo: 2-entry FIFO holding BRAM read data that the stream has not yet taken
module act_skid_fifo #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);
  logic [DWIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  always_comb begin
    count_d = count_q + 2'(push) - 2'(pop);
    head_d  = (pop || count_q == 2'd0) ? ((count_q == 2'd2) ? tail_q : din) : head_q;
    tail_d  = push ? din : tail_q;
  end
  always_ff @(posedge clk) begin
    count_q <= rst ? 2'd0 : count_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
  end
  assign dout  = head_q;
  assign count = count_q;
  assign full  = count_q == 2'd2;
  assign empty = count_q == 2'd0;
endmodule

// File: rtl/act_buf_stream_reader.sv
// act_buf_stream_reader: drains a full activation buffer from BRAM as an AXI-Stream frame
module act_buf_stream_reader
  import act_buf_stream_reader_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int NUM_WORDS = 16384
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              SyncSig_V,
  input  logic              SyncSig_V_ap_vld,
  output logic              SyncSig_V_ap_ack,
  output logic              FreeSig_V,
  output logic              FreeSig_V_ap_vld,
  input  logic              FreeSig_V_ap_ack,
  output logic [AWIDTH-1:0] ActBuf_address0,
  output logic              ActBuf_ce0,
  input  logic [DWIDTH-1:0] ActBuf_q0,
  output logic [DWIDTH-1:0] ActOut_V_V_TDATA,
  output logic              ActOut_V_V_TVALID,
  output logic              ActOut_V_V_TLAST,
  input  logic              ActOut_V_V_TREADY,
  output logic              busy
);
  localparam logic [AWIDTH:0] LAST_IDX = (AWIDTH+1)'(NUM_WORDS - 1);
  localparam logic [AWIDTH:0] NW       = (AWIDTH+1)'(NUM_WORDS);
  state_t            state_q, state_d;
  logic [AWIDTH:0]   addr_q, addr_d, beat_q, beat_d;
  logic              infl_q, infl_d;
  logic [DWIDTH-1:0] fifo_dout;
  logic [1:0]        fifo_count;
  logic              fifo_full, fifo_empty;
  logic              tok, issue, tvalid, beat, push, pop;
  act_skid_fifo #(.DWIDTH(DWIDTH)) u_fifo (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (push),
    .pop   (pop),
    .din   (ActBuf_q0),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      infl_q  <= infl_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (tok && SyncSig_V == TOKEN_FULL) ? READ : IDLE;
      READ:    state_d = (issue && addr_q == LAST_IDX) ? DRAIN : READ;
      DRAIN:   state_d = (fifo_empty && !infl_q && beat_q == NW) ? RELEASE : DRAIN;
      RELEASE: state_d = FreeSig_V_ap_ack ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
  end
  // A word still in flight bypasses the empty FIFO so the first beat leaves one cycle after issue
  always_comb begin
    tok               = SyncSig_V_ap_vld && state_q == IDLE;
    issue             = state_q == READ && !fifo_full && ({1'b0, fifo_count} + 3'(infl_q)) < 3'd2;
    tvalid            = !fifo_empty || infl_q;
    beat              = tvalid && ActOut_V_V_TREADY;
    push              = infl_q && !(fifo_empty && ActOut_V_V_TREADY);
    pop               = !fifo_empty && ActOut_V_V_TREADY;
    addr_d            = (state_q == IDLE) ? '0 : issue ? addr_q + 1'b1 : addr_q;
    beat_d            = (state_q == IDLE) ? '0 : beat ? beat_q + 1'b1 : beat_q;
    infl_d            = issue;
    SyncSig_V_ap_ack  = tok;
    FreeSig_V         = TOKEN_FREE;
    FreeSig_V_ap_vld  = state_q == RELEASE;
    ActBuf_address0   = addr_q[AWIDTH-1:0];
    ActBuf_ce0        = issue;
    ActOut_V_V_TDATA  = fifo_empty ? ActBuf_q0 : fifo_dout;
    ActOut_V_V_TVALID = tvalid;
    ActOut_V_V_TLAST  = tvalid && beat_q == LAST_IDX;
    busy              = state_q != IDLE;
  end
endmodule

// File: tb/tb_act_buf_stream_reader.sv
// tb_act_buf_stream_reader: scoreboard bench with a frame-level reference model
module tb_act_buf_stream_reader;
  localparam int DW = 8, AW = 14, NW = 8;
  typedef struct {logic [DW-1:0] d; logic l;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic sync = 1'b0, sync_vld = 1'b0, sync_ack, free, free_vld, free_ack = 1'b0;
  logic [AW-1:0] addr;
  logic ce0, tvalid, tlast, tready = 1'b0, busy;
  logic [DW-1:0] q0 = '0, tdata;
  logic s_sync = 1'b0, s_vld = 1'b0, s_ack, s_free, s_free_vld, s_ce0, s_tvalid, s_tlast, s_busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_q0 = '0, s_tdata;
  act_buf_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(NW)) dut (
    .ap_clk(clk), .ap_rst(rst), .SyncSig_V(sync), .SyncSig_V_ap_vld(sync_vld),
    .SyncSig_V_ap_ack(sync_ack), .FreeSig_V(free), .FreeSig_V_ap_vld(free_vld),
    .FreeSig_V_ap_ack(free_ack), .ActBuf_address0(addr), .ActBuf_ce0(ce0), .ActBuf_q0(q0),
    .ActOut_V_V_TDATA(tdata), .ActOut_V_V_TVALID(tvalid), .ActOut_V_V_TLAST(tlast),
    .ActOut_V_V_TREADY(tready), .busy(busy));
  act_buf_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(1)) dut1 (
    .ap_clk(clk), .ap_rst(rst), .SyncSig_V(s_sync), .SyncSig_V_ap_vld(s_vld),
    .SyncSig_V_ap_ack(s_ack), .FreeSig_V(s_free), .FreeSig_V_ap_vld(s_free_vld),
    .FreeSig_V_ap_ack(1'b1), .ActBuf_address0(s_addr), .ActBuf_ce0(s_ce0), .ActBuf_q0(s_q0),
    .ActOut_V_V_TDATA(s_tdata), .ActOut_V_V_TVALID(s_tvalid), .ActOut_V_V_TLAST(s_tlast),
    .ActOut_V_V_TREADY(1'b1), .busy(s_busy));
  // BRAM holds mem[i] = i + 3, one-cycle read latency
  always @(posedge clk) begin
    if (ce0) q0 <= DW'(32'(addr) + 3);
    if (s_ce0) s_q0 <= DW'(32'(s_addr) + 3);
  end
  int rdy_mode = 1, ack_mode = 1;
  always @(posedge clk) begin
    #1;
    tready   = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    free_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ack_mode);
  end
  int vectors = 0, errors = 0;
  int cyc = 0, outst = 0, beats = 0, frames = 0;
  int hs_cyc = 0, rel_cyc = 0, first_cyc = 0, last_cyc = 0;
  bit saw_ce = 0, saw_busy = 0, saw_tv = 0, prev_stall = 0;
  logic [DW-1:0] prev_d = '0;
  exp_t sb[$];
  exp_t e;
  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  // Monitor: the reference model expands each accepted full token into NW expected beats
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      outst = 0;
      beats = 0;
      prev_stall = 0;
    end else begin
      if (sync_vld && sync_ack && sync) begin
        for (int i = 0; i < NW; i++) sb.push_back('{d: DW'(i + 3), l: (i == NW - 1)});
        hs_cyc = cyc;
        beats = 0;
      end
      if (ce0) check("ce0_outstanding_lt2", 32'(outst < 2), 1);
      saw_ce |= ce0;
      saw_busy |= busy;
      saw_tv |= tvalid;
      if (prev_stall) begin
        check("tvalid_hold", 32'(tvalid), 1);
        check("tdata_hold", 32'(tdata), 32'(prev_d));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) check("unexpected_beat", 0, 1);
        else begin
          e = sb.pop_front();
          check("tdata", 32'(tdata), 32'(e.d));
          check("tlast", 32'(tlast), 32'(e.l));
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      outst += int'(ce0) - int'(tvalid && tready);
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      if (free_vld && free_ack) begin
        check("free_payload", 32'(free), 1);
        check("all_beats_before_release", 32'(sb.size()), 0);
        rel_cyc = cyc;
        frames++;
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send_token(input logic v, output int n);
    @(posedge clk);
    #1;
    sync = v;
    sync_vld = 1'b1;
    n = 0;
    tick();
    while (!sync_ack && n < 50) begin
      n++;
      tick();
    end
    if (n == 50) check("token_ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    sync_vld = 1'b0;
  endtask
  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      n++;
      tick();
    end
    check("frame_timeout", 32'(frames >= target), 1);
  endtask
  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target && n < 200) begin
      n++;
      tick();
    end
    check("beat_timeout", 32'(beats >= target), 1);
  endtask
  int w, f, n;
  initial begin
    repeat (3) @(posedge clk);
    tick();
    check("rst_ack", 32'(sync_ack), 0);
    check("rst_free_vld", 32'(free_vld), 0);
    check("rst_ce0", 32'(ce0), 0);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_free_payload", 32'(free), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    // Full-rate frame: first beat two cycles after the handshake, then one per cycle
    f = frames;
    send_token(1'b1, w);
    wait_frames(f + 1, 100);
    check("first_beat_latency", 32'(first_cyc - hs_cyc), 2);
    check("frame_beat_span", 32'(last_cyc - first_cyc), NW - 1);
    tick();
    check("idle_after_release", 32'(busy), 0);
    // Discarded empty token
    saw_ce = 0;
    saw_busy = 0;
    saw_tv = 0;
    send_token(1'b0, w);
    check("zero_token_ack_wait", 32'(w), 0);
    repeat (10) tick();
    check("zero_token_ce0", 32'(saw_ce), 0);
    check("zero_token_busy", 32'(saw_busy), 0);
    check("zero_token_tvalid", 32'(saw_tv), 0);
    // Long downstream stall mid-frame
    f = frames;
    send_token(1'b1, w);
    wait_beats(3);
    rdy_mode = 0;
    repeat (20) begin
      tick();
      check("stall_outstanding_le2", 32'(outst <= 2), 1);
    end
    rdy_mode = 1;
    wait_frames(f + 1, 100);
    // Token held valid across a frame is taken right after release completes
    f = frames;
    @(posedge clk);
    #1;
    sync = 1'b1;
    sync_vld = 1'b1;
    wait_frames(f + 1, 100);
    tick();
    check("back_to_back_accept", 32'(hs_cyc - rel_cyc), 1);
    @(posedge clk);
    #1;
    sync_vld = 1'b0;
    wait_frames(f + 2, 100);
    // Reset mid-frame aborts without release, next frame restarts at word 0
    f = frames;
    send_token(1'b1, w);
    wait_beats(4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("abort_tvalid", 32'(tvalid), 0);
    check("abort_ce0", 32'(ce0), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_release", 32'(frames), 32'(f));
    send_token(1'b1, w);
    wait_frames(f + 1, 100);
    // Random backpressure and release acceptance
    rdy_mode = 2;
    ack_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      f = frames;
      send_token(1'b1, w);
      wait_frames(f + 1, 400);
    end
    rdy_mode = 1;
    ack_mode = 1;
    // Single-word frame
    @(posedge clk);
    #1;
    s_sync = 1'b1;
    s_vld = 1'b1;
    tick();
    check("nw1_ack", 32'(s_ack), 1);
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    n = 0;
    while (!s_tvalid && n < 20) begin
      n++;
      tick();
    end
    check("nw1_tvalid", 32'(s_tvalid), 1);
    check("nw1_tdata", 32'(s_tdata), 3);
    check("nw1_tlast", 32'(s_tlast), 1);
    tick();
    check("nw1_single_beat", 32'(s_tvalid), 0);
    n = 0;
    while (!s_free_vld && n < 20) begin
      n++;
      tick();
    end
    check("nw1_release", 32'(s_free_vld), 1);
    tick();
    check("nw1_idle", 32'(s_busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/act_buf_stream_reader.md
Name: act_buf_stream_reader

Overview:
- Read-side counterpart of the activation-buffer writer.
- Waits for the writer's "buffer full" sync token, then streams NUM_WORDS activations from the activation BRAM read port as an AXI-Stream.
- Returns a "buffer free" token to the writer once the last word has been accepted downstream.
- Used where a layer's activation buffer must be forwarded or drained to DMA instead of being consumed by a PE.

Parameters:
- DWIDTH, 8, activation word width (BRAM data and TDATA).
- AWIDTH, 14, BRAM address width.
- NUM_WORDS, 16384, words per frame (1..2^AWIDTH).

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- SyncSig_V  in  1  token payload from writer (1 = buffer full).
- SyncSig_V_ap_vld  in  1  token valid.
- SyncSig_V_ap_ack  out  1  token accept.
- FreeSig_V  out  1  release payload, constant 1.
- FreeSig_V_ap_vld  out  1  release valid.
- FreeSig_V_ap_ack  in  1  release accept by writer.
- ActBuf_address0  out  AWIDTH  BRAM read address.
- ActBuf_ce0  out  1  BRAM read enable.
- ActBuf_q0  in  DWIDTH  BRAM read data, valid 1 cycle after ce0.
- ActOut_V_V_TDATA  out  DWIDTH  stream data.
- ActOut_V_V_TVALID  out  1  stream valid.
- ActOut_V_V_TLAST  out  1  high on word NUM_WORDS-1.
- ActOut_V_V_TREADY  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: ap_rst high at a rising edge forces state IDLE, read address 0, FIFO empty, in-flight flag 0. All outputs then read 0 (ack, vld, ce0, TVALID, TLAST, busy; FreeSig_V stays 1).
- Reset mid-frame aborts the frame. No FreeSig token is sent, and any unread data is discarded.
- Handshakes: a token transfers in a cycle where vld and ack are both high. An AXIS beat transfers where TVALID and TREADY are both high.
- State IDLE: SyncSig_V_ap_ack = 1.
  - On vld & SyncSig_V = 1: go to READ with addr = 0.
  - On vld & SyncSig_V = 0: the token is consumed and discarded; stay in IDLE.
- State READ: issue a read (ce0 = 1, address = addr) when FIFO occupancy + in-flight < 2. Addr increments on each issue.
  - After issuing address NUM_WORDS-1, go to DRAIN.
  - Issuing and FIFO pop may happen in the same cycle.
  - ce0 = 0 in all states except a READ issue cycle.
- Read pipeline: ActBuf_q0 is captured into the FIFO one cycle after issue (in-flight flag).
  - FIFO depth is 2. Data is never lost under arbitrary TREADY.
  - With TREADY held at 1: sustained throughput is 1 word/cycle, and the first TVALID appears 2 cycles after the token handshake.
- TLAST: derived from a separate output-beat counter, not from the read address. High only with the beat of index NUM_WORDS-1.
- State DRAIN: wait until the FIFO is empty, no read is in flight, and the last beat has transferred; then go to RELEASE.
- State RELEASE: FreeSig_V_ap_vld = 1 until FreeSig_V_ap_ack; then go to IDLE.
  - The ack may already be high in the cycle vld rises, giving a 1-cycle release.
- Back-to-back frames: a new sync token is accepted only in IDLE, so vld held high during a frame is accepted the cycle after the release completes.
- TDATA is stable while TVALID is high and TREADY is low (AXIS rule). TVALID does not depend combinationally on TREADY.
- Counter widths: address counter AWIDTH+1 bits to avoid wrap when NUM_WORDS = 2^AWIDTH. Beat counter the same.
- NUM_WORDS = 1: the single beat carries TLAST = 1.

Decomposition:
- Shared package: state encoding (IDLE, READ, DRAIN, RELEASE), DWIDTH/AWIDTH defaults, the sync-token constant 1'b1 for "full" and "free".
- One sub-module, act_skid_fifo: 2-entry DWIDTH FIFO with push/pop, count[1:0] and full/empty flags, synchronous active-high reset.

Test Plan (NUM_WORDS = 8 unless noted, BRAM model preloaded with mem[i] = i+3):
- TREADY = 1, single token at cycle 10 -> TDATA 3,4,...,10 on consecutive cycles starting cycle 12; TLAST only with 10; FreeSig vld rises after the last beat; ack given -> IDLE.
- TREADY random 50%, 1000 frames -> every frame is 3..10 in order, no duplicates or drops; ce0 never issued with occupancy + in-flight = 2.
- TREADY = 0 for 20 cycles mid-frame -> at most 2 reads outstanding; TDATA held stable; resumes correctly.
- Token with SyncSig_V = 0 -> ack in 1 cycle; no ce0; no stream output; busy stays 0.
- ap_rst asserted at beat 4 -> next cycle TVALID = 0, ce0 = 0, busy = 0; new token restarts from address 0 (TDATA 3).
- NUM_WORDS = 1 and NUM_WORDS = 16384 (AWIDTH = 14) -> single beat with TLAST; full-depth frame has TLAST on word 16383 and addresses do not wrap early.
